// File: rtl/plic_lite_pkg.sv
// Shared definitions for the plic_lite external interrupt controller: register offsets,
// source-ID type and the interrupt codes used to route irq_o into mip.
package plic_lite_pkg;

  typedef logic [4:0] plicSrcId_t;

  typedef enum logic [5:0] {
    S_SW_INT  = 6'd1,
    M_SW_INT  = 6'd3,
    S_TIM_INT = 6'd5,
    M_TIM_INT = 6'd7,
    S_EXT_INT = 6'd9,
    M_EXT_INT = 6'd11
  } interruptionCode_e;

  localparam logic [7:0] PLIC_PRIO_BASE = 8'h00;
  localparam logic [7:0] PLIC_PENDING   = 8'h80;
  localparam logic [7:0] PLIC_ENABLE    = 8'h84;
  localparam logic [7:0] PLIC_THRESHOLD = 8'h88;
  localparam logic [7:0] PLIC_CLAIM     = 8'h8C;
  localparam logic [7:0] PLIC_TRIGGER   = 8'h90;

endpackage

// File: rtl/plic_gateway.sv
// Per-source interrupt gateway: pending / in-flight tracking, plus edge detection and a
// one-deep edge latch when PLIC_EDGE_TRIG_EN is defined.
module plic_gateway (
  input  logic clk,
  input  logic reset_n,
  input  logic src_i,
`ifdef PLIC_EDGE_TRIG_EN
  input  logic edge_mode_i,
`endif
  input  logic claim_i,
  input  logic complete_i,
  output logic pending_o
);

  logic pending_q, pending_d;
  logic in_flight_q, in_flight_d;
  logic req;

`ifdef PLIC_EDGE_TRIG_EN
  logic prev_q, latch_q, latch_d, rise;

  assign rise = src_i & ~prev_q;
  assign req  = edge_mode_i ? (rise | latch_q) : src_i;

  // Edges seen while busy collapse into one latched request, replayed once idle.
  always_comb begin
    latch_d = latch_q;
    if (!edge_mode_i) begin
      latch_d = 1'b0;
    end else if (rise && (pending_q || in_flight_q)) begin
      latch_d = 1'b1;
    end else if (!pending_q && !in_flight_q) begin
      latch_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      prev_q  <= src_i;
      latch_q <= latch_d;
    end
  end
`else
  assign req = src_i;
`endif

  always_comb begin
    pending_d   = pending_q;
    in_flight_d = in_flight_q;
    if (claim_i && pending_q) begin
      pending_d   = 1'b0;
      in_flight_d = 1'b1;
    end else if (complete_i && in_flight_q) begin
      in_flight_d = 1'b0;
    end else if (req && !pending_q && !in_flight_q) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_q   <= 1'b0;
      in_flight_q <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/plic_lite.sv
// Platform-level external interrupt controller; irq_o feeds mip bit M_EXT_INT.
// Define PLIC_EDGE_TRIG_EN to add the TRIGGER register and edge-mode gateways.
module plic_lite
  import plic_lite_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic               en_i,
  input  logic [3:0]         we_i,
  input  logic [7:0]         addr_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic               irq_o
);

  logic [NUM_SRC:1][PRIO_W-1:0] prio_q, prio_d;
  logic [NUM_SRC:1]             enable_q, enable_d;
  logic [PRIO_W-1:0]            threshold_q, threshold_d;
  plicSrcId_t                   best_id_q, best_id_d;
  logic [PRIO_W-1:0]            best_prio_q, best_prio_d;
  logic [31:0]                  data_q, rdata;
  logic [NUM_SRC:1]             pending, claim_vec, complete_vec;
  logic [5:0]                   word;
  logic                         rd, wr, sel_claim;

  assign word      = addr_i[7:2];
  assign rd        = en_i & ~(|we_i);
  assign wr        = en_i & (|we_i);
  assign sel_claim = (word == PLIC_CLAIM[7:2]);

`ifdef PLIC_EDGE_TRIG_EN
  logic [NUM_SRC:1] trigger_q, trigger_d;

  always_comb begin
    trigger_d = trigger_q;
    if (wr && word == PLIC_TRIGGER[7:2]) trigger_d = data_i[NUM_SRC:1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) trigger_q <= '0;
    else          trigger_q <= trigger_d;
  end
`endif

  for (genvar i = 1; i <= NUM_SRC; i++) begin : g_gw
    assign claim_vec[i]    = rd && sel_claim && (best_id_q == plicSrcId_t'(i));
    assign complete_vec[i] = wr && sel_claim && (data_i[4:0] == 5'(i));

    plic_gateway u_gw (
      .clk        (clk),
      .reset_n    (reset_n),
      .src_i      (src_i[i-1]),
`ifdef PLIC_EDGE_TRIG_EN
      .edge_mode_i(trigger_q[i]),
`endif
      .claim_i    (claim_vec[i]),
      .complete_i (complete_vec[i]),
      .pending_o  (pending[i])
    );
  end

  // A source being claimed this edge is masked so it cannot win twice in a row.
  always_comb begin
    best_id_d   = '0;
    best_prio_d = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      if (pending[i] && !claim_vec[i] && enable_q[i] && (prio_q[i] > threshold_q) &&
          (prio_q[i] > best_prio_d)) begin
        best_id_d   = plicSrcId_t'(i);
        best_prio_d = prio_q[i];
      end
    end
  end

  always_comb begin
    prio_d      = prio_q;
    enable_d    = enable_q;
    threshold_d = threshold_q;
    if (wr) begin
      for (int unsigned i = 1; i <= NUM_SRC; i++) begin
        if (word == 6'(i)) prio_d[i] = data_i[PRIO_W-1:0];
      end
      if (word == PLIC_ENABLE[7:2])    enable_d    = data_i[NUM_SRC:1];
      if (word == PLIC_THRESHOLD[7:2]) threshold_d = data_i[PRIO_W-1:0];
    end
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 1; i <= NUM_SRC; i++) begin
      if (word == 6'(i)) rdata[PRIO_W-1:0] = prio_q[i];
    end
    if (word == PLIC_PENDING[7:2])   rdata[NUM_SRC:1]  = pending;
    if (word == PLIC_ENABLE[7:2])    rdata[NUM_SRC:1]  = enable_q;
    if (word == PLIC_THRESHOLD[7:2]) rdata[PRIO_W-1:0] = threshold_q;
    if (sel_claim)                   rdata[4:0]        = best_id_q;
`ifdef PLIC_EDGE_TRIG_EN
    if (word == PLIC_TRIGGER[7:2])   rdata[NUM_SRC:1]  = trigger_q;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q      <= '0;
      enable_q    <= '0;
      threshold_q <= '0;
      best_id_q   <= '0;
      best_prio_q <= '0;
      data_q      <= '0;
    end else begin
      prio_q      <= prio_d;
      enable_q    <= enable_d;
      threshold_q <= threshold_d;
      best_id_q   <= best_id_d;
      best_prio_q <= best_prio_d;
      if (rd) data_q <= rdata;
    end
  end

  assign data_o = data_q;
  assign irq_o  = (best_id_q != '0);

  // best_prio_q is kept only for debug visibility.
  logic unused_sig;
  assign unused_sig = ^{addr_i[1:0], data_i, best_prio_q};

endmodule

// File: tb/tb_plic_lite.sv
// Directed self-checking bench for plic_lite; covers the edge-trigger path when
// PLIC_EDGE_TRIG_EN is defined.
module tb_plic_lite;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  src_i = '0;
  logic        en_i = 1'b0;
  logic [3:0]  we_i = '0;
  logic [7:0]  addr_i = '0;
  logic [31:0] data_i = '0;
  logic [31:0] data_o;
  logic        irq_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd_val;

  always #5 clk = ~clk;

  plic_lite #(
    .NUM_SRC(8),
    .PRIO_W (3)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .src_i  (src_i),
    .en_i   (en_i),
    .we_i   (we_i),
    .addr_i (addr_i),
    .data_i (data_i),
    .data_o (data_o),
    .irq_o  (irq_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    en_i = 1'b1; we_i = 4'hF; addr_i = a; data_i = d;
    @(negedge clk);
    en_i = 1'b0; we_i = '0; data_i = '0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk);
    en_i = 1'b1; we_i = '0; addr_i = a;
    @(negedge clk);
    en_i = 1'b0;
    d = data_o;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick(3);
    reset_n = 1'b1;
    tick(1);

    // Reset state
    chk("rst_irq", {31'd0, irq_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    bus_rd(8'h04, rd_val); chk("rst_prio1", rd_val, 32'd0);
    bus_rd(8'h88, rd_val); chk("rst_thresh", rd_val, 32'd0);

    // Unmapped offsets
    bus_wr(8'hFC, 32'hFFFF_FFFF);
    bus_rd(8'hFC, rd_val); chk("unmapped_fc", rd_val, 32'd0);
    bus_rd(8'h00, rd_val); chk("unmapped_00", rd_val, 32'd0);

    // Test 1: single source, two-cycle latency, claim
    bus_wr(8'h0C, 32'd2);
    bus_wr(8'h84, 32'h08);
    bus_wr(8'h88, 32'd0);
    bus_rd(8'h0C, rd_val); chk("t1_prio3", rd_val, 32'd2);
    @(negedge clk); src_i[2] = 1'b1;
    @(posedge clk); #1 chk("t1_irq_c1", {31'd0, irq_o}, 32'd0);
    @(posedge clk); #1 chk("t1_irq_c2", {31'd0, irq_o}, 32'd1);
    @(negedge clk); src_i[2] = 1'b0;
    bus_rd(8'h80, rd_val); chk("t1_pend_pre", rd_val, 32'h08);
    bus_rd(8'h8C, rd_val); chk("t1_claim", rd_val, 32'd3);
    tick(1); chk("t1_irq_after", {31'd0, irq_o}, 32'd0);
    bus_rd(8'h80, rd_val); chk("t1_pend_post", rd_val, 32'd0);
    bus_wr(8'h8C, 32'd3);

    // Test 2: priority ordering and tie-break to lowest ID
    bus_wr(8'h04, 32'd4);
    bus_wr(8'h14, 32'd4);
    bus_wr(8'h18, 32'd7);
    bus_wr(8'h84, 32'h62);
    @(negedge clk); src_i = 8'h31;
    tick(3);
    bus_rd(8'h8C, rd_val); chk("t2_claim_a", rd_val, 32'd6);
    src_i[5] = 1'b0;
    bus_wr(8'h8C, 32'd6);
    tick(2);
    bus_rd(8'h8C, rd_val); chk("t2_claim_b", rd_val, 32'd1);
    src_i[0] = 1'b0;
    bus_wr(8'h8C, 32'd1);
    tick(2);
    bus_rd(8'h8C, rd_val); chk("t2_claim_c", rd_val, 32'd5);
    src_i[4] = 1'b0;
    bus_wr(8'h8C, 32'd5);
    tick(2);
    bus_rd(8'h8C, rd_val); chk("t2_claim_d", rd_val, 32'd0);
    tick(1); chk("t2_irq_end", {31'd0, irq_o}, 32'd0);

    // Test 3: threshold is a strict comparison
    bus_wr(8'h08, 32'd4);
    bus_wr(8'h84, 32'h04);
    bus_wr(8'h88, 32'd4);
    @(negedge clk); src_i[1] = 1'b1;
    tick(4); chk("t3_irq_blocked", {31'd0, irq_o}, 32'd0);
    bus_wr(8'h88, 32'd3);
    @(posedge clk); @(posedge clk); #1 chk("t3_irq_open", {31'd0, irq_o}, 32'd1);

    // Test 4: level re-arm after COMPLETE; bogus COMPLETE ignored
    bus_rd(8'h8C, rd_val); chk("t4_claim", rd_val, 32'd2);
    tick(3); chk("t4_irq_inflight", {31'd0, irq_o}, 32'd0);
    bus_rd(8'h80, rd_val); chk("t4_pend_inflight", rd_val, 32'd0);
    bus_wr(8'h8C, 32'd2);
    tick(3); chk("t4_irq_rearm", {31'd0, irq_o}, 32'd1);
    bus_rd(8'h80, rd_val); chk("t4_pend_rearm", rd_val, 32'h04);
    bus_wr(8'h8C, 32'd7);
    tick(2);
    bus_rd(8'h80, rd_val); chk("t4_pend_c7", rd_val, 32'h04);
    chk("t4_irq_c7", {31'd0, irq_o}, 32'd1);

    // Test 5: async reset with ID 4 in flight
    bus_wr(8'h10, 32'd5);
    bus_wr(8'h84, 32'h14);
    @(negedge clk); src_i[3] = 1'b1;
    tick(3);
    bus_rd(8'h8C, rd_val); chk("t5_claim", rd_val, 32'd4);
    tick(2); chk("t5_irq_pre", {31'd0, irq_o}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk("t5_rst_irq", {31'd0, irq_o}, 32'd0);
    chk("t5_rst_data", data_o, 32'd0);
    src_i = '0;
    tick(2);
    reset_n = 1'b1;
    tick(1);
    bus_rd(8'h10, rd_val); chk("t5_prio4", rd_val, 32'd0);
    bus_rd(8'h84, rd_val); chk("t5_enable", rd_val, 32'd0);
    bus_rd(8'h80, rd_val); chk("t5_pending", rd_val, 32'd0);

`ifdef PLIC_EDGE_TRIG_EN
    // Test 6: edge mode, merged edges while in flight
    bus_wr(8'h90, 32'h02);
    bus_wr(8'h04, 32'd1);
    bus_wr(8'h84, 32'h02);
    bus_rd(8'h90, rd_val); chk("t6_trigger", rd_val, 32'h02);
    @(negedge clk); src_i[0] = 1'b1;
    @(negedge clk); src_i[0] = 1'b0;
    tick(3);
    bus_rd(8'h8C, rd_val); chk("t6_claim_a", rd_val, 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); src_i[0] = 1'b1;
      @(negedge clk); src_i[0] = 1'b0;
    end
    tick(2); chk("t6_irq_inflight", {31'd0, irq_o}, 32'd0);
    bus_wr(8'h8C, 32'd1);
    tick(3);
    bus_rd(8'h8C, rd_val); chk("t6_claim_b", rd_val, 32'd1);
    bus_wr(8'h8C, 32'd1);
    tick(3);
    bus_rd(8'h8C, rd_val); chk("t6_claim_c", rd_val, 32'd0);
`else
    bus_wr(8'h90, 32'hFF);
    bus_rd(8'h90, rd_val); chk("trigger_absent", rd_val, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
